tcdm_rr_port_arbiter: RTL and testbench

//  Shares one TCDM initiator port between NB_REQ requesters, e.g. an axi2mem lane and a DMA/HWPE lane.

---
 rtl/tcdm_rr_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_tcdm_rr_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_rr_port_arbiter.sv
// Round-robin arbiter sharing one TCDM initiator port between NB_REQ requester lanes.
// An outstanding-ID FIFO routes each in-order response back to the lane that issued it.
module tcdm_rr_port_arbiter #(
    parameter int NB_REQ     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_OUTST  = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NB_REQ-1:0]              req_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]   add_i,
    input  logic [NB_REQ-1:0]              wen_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0]   data_i,
    input  logic [NB_REQ*DATA_WIDTH/8-1:0] be_i,
    output logic [NB_REQ-1:0]              gnt_o,
    output logic [NB_REQ-1:0]              r_valid_o,
    output logic [DATA_WIDTH-1:0]          r_data_o,
    output logic                           req_o,
    output logic [ADDR_WIDTH-1:0]          add_o,
    output logic                           wen_o,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic [DATA_WIDTH/8-1:0]        be_o,
    input  logic                           gnt_i,
    input  logic                           r_valid_i,
    input  logic [DATA_WIDTH-1:0]          r_data_i,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int ID_W     = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int CNT_W    = $clog2(MAX_OUTST + 1);
    localparam int PTR_W    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  head_id;
    logic [ID_W-1:0]  id_fifo [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             any_req;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             err_q;

    // First requesting lane at or after ptr, wrapping; lane 0 when nobody requests.
    function automatic logic [ID_W-1:0] pick_winner(input logic [NB_REQ-1:0] req,
                                                     input logic [ID_W-1:0]   ptr);
        logic [ID_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NB_REQ; k++) begin
            idx = (int'(ptr) + k) % NB_REQ;
            if (!found && req[idx]) begin
                sel   = ID_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [ID_W-1:0] next_rr(input logic [ID_W-1:0] w);
        return ID_W'((int'(w) + 1) % NB_REQ);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign any_req = |req_i;
    assign full    = (count == CNT_W'(MAX_OUTST));
    assign empty   = (count == '0);
    assign win     = pick_winner(req_i, rr_ptr);
    assign head_id = id_fifo[rd_ptr];

    // Full is taken from the registered count only, so a pop never frees a slot in its own cycle.
    assign req_o = any_req & ~full & ~rst_i;
    assign push  = req_o & gnt_i;
    assign pop   = r_valid_i & ~empty & ~rst_i;

    assign gnt_o     = push ? (NB_REQ'(1) << win) : '0;
    assign r_valid_o = pop ? (NB_REQ'(1) << head_id) : '0;
    assign r_data_o  = r_data_i;
    assign busy_o    = ~rst_i & (any_req | ~empty);
    assign err_o     = err_q;

    always_comb begin
        add_o  = add_i[ADDR_WIDTH-1:0];
        wen_o  = wen_i[0];
        data_o = data_i[DATA_WIDTH-1:0];
        be_o   = be_i[BE_WIDTH-1:0];
        for (int i = 1; i < NB_REQ; i++) begin
            if (win == ID_W'(i)) begin
                add_o  = add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                wen_o  = wen_i[i];
                data_o = data_i[i*DATA_WIDTH +: DATA_WIDTH];
                be_o   = be_i[i*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (push) begin
                rr_ptr <= next_rr(win);
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            // A response with nothing outstanding is dropped and flagged until reset.
            if (r_valid_i && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_fifo[wr_ptr] <= win;
        end
    end

endmodule

// File: tb/tb_tcdm_rr_port_arbiter.sv
// Bench for tcdm_rr_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_tcdm_rr_port_arbiter;

    localparam int NB = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NB-1:0]    req = '0;
    logic [NB*AW-1:0] add = '0;
    logic [NB-1:0]    wen = '0;
    logic [NB*DW-1:0] wdata = '0;
    logic [NB*BW-1:0] be = '0;
    logic             gnt_in = 1'b0;
    logic             rvalid_in = 1'b0;
    logic [DW-1:0]    rdata_in = '0;

    logic [NB-1:0] gnt_o;
    logic [NB-1:0] r_valid_o;
    logic [DW-1:0] r_data_o;
    logic          req_o;
    logic [AW-1:0] add_o;
    logic          wen_o;
    logic [DW-1:0] data_o;
    logic [BW-1:0] be_o;
    logic          busy_o;
    logic          err_o;

    int n_checks = 0;
    int n_err = 0;

    tcdm_rr_port_arbiter #(
        .NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .add_i(add), .wen_i(wen), .data_i(wdata), .be_i(be),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_data_o(r_data_o),
        .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .data_o(data_o), .be_o(be_o),
        .gnt_i(gnt_in), .r_valid_i(rvalid_in), .r_data_i(rdata_in),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: round-robin pointer, queue of outstanding lane IDs, sticky error.
    int            m_ptr = 0;
    int            m_q[$];
    bit            m_err = 1'b0;
    logic [NB-1:0] m_last_gnt = '0;
    int            mw;
    bit            mhs;

    function automatic int m_winner();
        for (int k = 0; k < NB; k++) begin
            if (req[(m_ptr + k) % NB]) return (m_ptr + k) % NB;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr = 0;
            m_q.delete();
            m_err = 1'b0;
            m_last_gnt = '0;
        end else begin
            mw  = m_winner();
            mhs = (|req) && (m_q.size() < MO) && gnt_in;
            m_last_gnt = mhs ? (NB'(1) << mw) : '0;
            if (rvalid_in) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (mhs) begin
                m_q.push_back(mw);
                m_ptr = (mw + 1) % NB;
            end
        end
    end

    // Compare process: every output against the model, mid-cycle.
    int            cw;
    bit            c_req;
    logic [NB-1:0] c_gnt;
    logic [NB-1:0] c_rv;

    always @(negedge clk) begin
        cw    = m_winner();
        c_req = !rst && (|req) && (m_q.size() < MO);
        c_gnt = (c_req && gnt_in) ? (NB'(1) << cw) : '0;
        c_rv  = (!rst && rvalid_in && m_q.size() > 0) ? (NB'(1) << m_q[0]) : '0;
        check("m_req_o", 64'(req_o), 64'(c_req));
        check("m_gnt_o", 64'(gnt_o), 64'(c_gnt));
        check("m_r_valid_o", 64'(r_valid_o), 64'(c_rv));
        check("m_r_data_o", 64'(r_data_o), 64'(rdata_in));
        check("m_add_o", 64'(add_o), 64'(add[cw*AW +: AW]));
        check("m_wen_o", 64'(wen_o), 64'(wen[cw]));
        check("m_data_o", 64'(data_o), 64'(wdata[cw*DW +: DW]));
        check("m_be_o", 64'(be_o), 64'(be[cw*BW +: BW]));
        check("m_busy_o", 64'(busy_o), 64'(!rst && ((|req) || m_q.size() > 0)));
        check("m_err_o", 64'(err_o), 64'(m_err));
    end

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        gnt_in = 1'b0;
        rvalid_in = 1'b0;
        sample();
        next();
        rst = 1'b0;
    endtask

    logic [NB-1:0] t2_g [4];
    logic [NB-1:0] t2_rv[4];
    logic [NB-1:0] t3_g [3];

    initial begin
        t2_g  = '{2'b01, 2'b10, 2'b01, 2'b10};
        t2_rv = '{2'b00, 2'b01, 2'b10, 2'b01};
        t3_g  = '{2'b01, 2'b10, 2'b00};

        // Reset holds everything quiet even with both lanes requesting.
        rst = 1'b1; req = 2'b11; gnt_in = 1'b1;
        sample();
        check("rst_req_o", 64'(req_o), 64'(0));
        check("rst_gnt_o", 64'(gnt_o), 64'(0));
        check("rst_busy_o", 64'(busy_o), 64'(0));
        check("rst_err_o", 64'(err_o), 64'(0));
        next();
        rst = 1'b0;
        sample();
        check("first_gnt", 64'(gnt_o), 64'(2'b01));
        next();

        // Fairness with single-cycle response latency.
        do_reset();
        add = {32'h0000_1111, 32'h0000_0000};
        for (int i = 0; i < 4; i++) begin
            req = 2'b11; gnt_in = 1'b1; rvalid_in = (i > 0);
            sample();
            check($sformatf("fair_gnt%0d", i), 64'(gnt_o), 64'(t2_g[i]));
            check($sformatf("fair_rv%0d", i), 64'(r_valid_o), 64'(t2_rv[i]));
            next();
        end
        req = 2'b00; gnt_in = 1'b0; rvalid_in = 1'b1;
        sample();
        check("fair_rv_last", 64'(r_valid_o), 64'(2'b10));
        next();
        rvalid_in = 1'b0;

        // Full: two grants, then stall; a pop reopens only on the following cycle.
        do_reset();
        req = 2'b11; gnt_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check($sformatf("full_gnt%0d", i), 64'(gnt_o), 64'(t3_g[i]));
            check($sformatf("full_req%0d", i), 64'(req_o), 64'(i < 2));
            next();
        end
        rvalid_in = 1'b1;
        sample();
        check("full_pop_gnt", 64'(gnt_o), 64'(2'b00));
        check("full_pop_rv", 64'(r_valid_o), 64'(2'b01));
        next();
        rvalid_in = 1'b0;
        sample();
        check("full_resume", 64'(gnt_o), 64'(2'b01));
        next();
        sample();
        check("full_again", 64'(gnt_o), 64'(2'b00));
        next();
        req = 2'b00; gnt_in = 1'b0; rvalid_in = 1'b1;
        sample();
        check("full_drain0", 64'(r_valid_o), 64'(2'b10));
        next();
        sample();
        check("full_drain1", 64'(r_valid_o), 64'(2'b01));
        next();
        rvalid_in = 1'b0;

        // Routing of responses back to the issuing lane.
        do_reset();
        add[AW +: AW] = 32'h100; wen[1] = 1'b1; req = 2'b10; gnt_in = 1'b1;
        sample();
        check("route_gnt1", 64'(gnt_o), 64'(2'b10));
        check("route_add1", 64'(add_o), 64'(32'h100));
        check("route_wen1", 64'(wen_o), 64'(1));
        next();
        add[0 +: AW] = 32'h200; wen[0] = 1'b0; wdata[0 +: DW] = 32'h1234_5678; req = 2'b01;
        sample();
        check("route_gnt0", 64'(gnt_o), 64'(2'b01));
        check("route_add0", 64'(add_o), 64'(32'h200));
        check("route_wen0", 64'(wen_o), 64'(0));
        check("route_data0", 64'(data_o), 64'(32'h1234_5678));
        next();
        req = 2'b00; gnt_in = 1'b0; rvalid_in = 1'b1; rdata_in = 32'hDEAD_BEEF;
        sample();
        check("route_rv1", 64'(r_valid_o), 64'(2'b10));
        check("route_rdata", 64'(r_data_o), 64'(32'hDEAD_BEEF));
        next();
        rdata_in = 32'hCAFE_F00D;
        sample();
        check("route_rv0", 64'(r_valid_o), 64'(2'b01));
        next();
        rvalid_in = 1'b0;
        sample();
        check("route_idle_busy", 64'(busy_o), 64'(0));
        next();

        // Spurious response sets a sticky error; async reset clears it at once.
        do_reset();
        rvalid_in = 1'b1;
        sample();
        check("spur_rv", 64'(r_valid_o), 64'(0));
        check("spur_err_pre", 64'(err_o), 64'(0));
        next();
        rvalid_in = 1'b0;
        sample();
        check("spur_err", 64'(err_o), 64'(1));
        next();
        sample();
        check("spur_sticky", 64'(err_o), 64'(1));
        #2 rst = 1'b1;
        #1 check("spur_async_clr", 64'(err_o), 64'(0));
        rst = 1'b0;
        next();
        sample();
        check("spur_after", 64'(err_o), 64'(0));
        next();

        // Stall: payload stable and pointer untouched while the port refuses grants.
        do_reset();
        add[AW +: AW] = 32'h0000_ABC0; wdata[DW +: DW] = 32'h55AA_55AA; req = 2'b10; gnt_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            check($sformatf("stall_add%0d", i), 64'(add_o), 64'(32'h0000_ABC0));
            check($sformatf("stall_data%0d", i), 64'(data_o), 64'(32'h55AA_55AA));
            check($sformatf("stall_busy%0d", i), 64'(busy_o), 64'(1));
            check($sformatf("stall_gnt%0d", i), 64'(gnt_o), 64'(0));
            next();
        end
        req = 2'b11; gnt_in = 1'b1;
        sample();
        check("stall_ptr", 64'(gnt_o), 64'(2'b01));
        next();

        // Randomized traffic; lanes hold their request until the model saw it granted.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < NB; i++) begin
                if (!req[i] || m_last_gnt[i]) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    add[i*AW +: AW] = $urandom();
                    wen[i] = 1'($urandom_range(0, 1));
                    wdata[i*DW +: DW] = $urandom();
                    be[i*BW +: BW] = BW'($urandom());
                end
            end
            gnt_in = ($urandom_range(0, 3) != 0);
            rvalid_in = (m_q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 299) == 0);
            rdata_in = $urandom();
            sample();
            next();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
